// File: rtl/regfile_sequencer_if.sv
// Instruction, register-file, datapath and data-memory signals of the sequencer.
// master: the sequencer; slave: the datapath/memory/instruction source side.
interface regfile_sequencer_if;
   logic [31:0] INSTR;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic [7:0]  ALU_RESULT;
   logic [7:0]  MEM_READDATA;
   logic        MEM_BUSYWAIT;
   logic [2:0]  OUT1ADDRESS;
   logic [2:0]  OUT2ADDRESS;
   logic [2:0]  INADDRESS;
   logic [7:0]  IN;
   logic        WRITE;
   logic [2:0]  ALUOP;
   logic        NEG_SEL;
   logic        IMM_SEL;
   logic [7:0]  IMM;
   logic        MEM_READ;
   logic        MEM_WRITE;
   logic [7:0]  ILLEGAL_CNT;

   modport master (
      input  INSTR, INSTR_VALID, ALU_RESULT,
      input  MEM_READDATA, MEM_BUSYWAIT,
      output INSTR_READY, OUT1ADDRESS, OUT2ADDRESS,
      output INADDRESS, IN, WRITE,
      output ALUOP, NEG_SEL, IMM_SEL, IMM,
      output MEM_READ, MEM_WRITE, ILLEGAL_CNT
   );

   modport slave (
      output INSTR, INSTR_VALID, ALU_RESULT,
      output MEM_READDATA, MEM_BUSYWAIT,
      input  INSTR_READY, OUT1ADDRESS, OUT2ADDRESS,
      input  INADDRESS, IN, WRITE,
      input  ALUOP, NEG_SEL, IMM_SEL, IMM,
      input  MEM_READ, MEM_WRITE, ILLEGAL_CNT
   );
endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle instruction sequencer for an 8-bit register-file datapath.
// Define ILLEGAL_OP_CNT_EN to build the saturating illegal-opcode counter.
module regfile_sequencer (
   input logic          CLOCK,
   input logic          RESET,
   regfile_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, DECODE, EXEC, MEMWAIT, WB
   } state_t;

   typedef struct packed {
      logic [7:0] op;
      logic [2:0] dest;
      logic [2:0] src1;
      logic [7:0] imm;
   } instr_t;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_LWD   = 8'h08;
   localparam logic [7:0] OP_SWD   = 8'h0A;

   state_t state, state_nx;
   instr_t ir_q, ir_nx;

   logic       ready_q, ready_nx;
   logic [2:0] out1_q, out1_nx;
   logic [2:0] out2_q, out2_nx;
   logic [7:0] imm_q, imm_nx;
   logic [2:0] aluop_q, aluop_nx;
   logic       neg_q, neg_nx;
   logic       immsel_q, immsel_nx;
   logic [2:0] inaddr_q, inaddr_nx;
   logic [7:0] in_q, in_nx;
   logic       write_q, write_nx;
   logic       rd_q, rd_nx;
   logic       wr_q, wr_nx;

   logic       is_alu, is_lwd, is_swd, legal;
   logic [2:0] dec_aluop;
   logic       dec_neg, dec_imm;

   always_comb begin
      is_alu    = 1'b0;
      is_lwd    = 1'b0;
      is_swd    = 1'b0;
      dec_aluop = 3'b000;
      dec_neg   = 1'b0;
      dec_imm   = 1'b0;
      unique case (ir_q.op)
         OP_LOADI: begin
            is_alu  = 1'b1;
            dec_imm = 1'b1;
         end
         OP_MOV: is_alu = 1'b1;
         OP_ADD: begin
            is_alu    = 1'b1;
            dec_aluop = 3'b001;
         end
         OP_SUB: begin
            is_alu    = 1'b1;
            dec_aluop = 3'b001;
            dec_neg   = 1'b1;
         end
         OP_AND: begin
            is_alu    = 1'b1;
            dec_aluop = 3'b010;
         end
         OP_OR: begin
            is_alu    = 1'b1;
            dec_aluop = 3'b011;
         end
         OP_LWD: is_lwd = 1'b1;
         OP_SWD: is_swd = 1'b1;
         default: ;
      endcase
   end

   assign legal = is_alu | is_lwd | is_swd;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nx;
   end

   // Every output is the registered copy of its *_nx value.
   always_comb begin
      state_nx  = state;
      ir_nx     = ir_q;
      ready_nx  = 1'b0;
      out1_nx   = out1_q;
      out2_nx   = out2_q;
      imm_nx    = imm_q;
      aluop_nx  = aluop_q;
      neg_nx    = neg_q;
      immsel_nx = immsel_q;
      inaddr_nx = inaddr_q;
      in_nx     = in_q;
      write_nx  = 1'b0;
      rd_nx     = 1'b0;
      wr_nx     = 1'b0;
      unique case (state)
         IDLE: begin
            ready_nx = 1'b1;
            if (ready_q && bus.INSTR_VALID) begin
               ir_nx.op   = bus.INSTR[31:24];
               ir_nx.dest = bus.INSTR[18:16];
               ir_nx.src1 = bus.INSTR[10:8];
               ir_nx.imm  = bus.INSTR[7:0];
               ready_nx   = 1'b0;
               state_nx   = DECODE;
            end
         end
         DECODE: begin
            out1_nx   = ir_q.src1;
            out2_nx   = ir_q.imm[2:0];
            imm_nx    = ir_q.imm;
            aluop_nx  = dec_aluop;
            neg_nx    = dec_neg;
            immsel_nx = dec_imm;
            state_nx  = legal ? EXEC : IDLE;
         end
         EXEC: begin
            if (is_alu) begin
               in_nx    = bus.ALU_RESULT;
               state_nx = WB;
            end else begin
               rd_nx    = is_lwd;
               wr_nx    = is_swd;
               state_nx = MEMWAIT;
            end
         end
         MEMWAIT: begin
            if (bus.MEM_BUSYWAIT) begin
               rd_nx = rd_q;
               wr_nx = wr_q;
            end else if (is_lwd) begin
               in_nx    = bus.MEM_READDATA;
               state_nx = WB;
            end else begin
               state_nx = IDLE;
            end
         end
         WB: begin
            write_nx  = 1'b1;
            inaddr_nx = ir_q.dest;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         ir_q     <= '0;
         ready_q  <= 1'b1;
         out1_q   <= '0;
         out2_q   <= '0;
         imm_q    <= '0;
         aluop_q  <= '0;
         neg_q    <= 1'b0;
         immsel_q <= 1'b0;
         inaddr_q <= '0;
         in_q     <= '0;
         write_q  <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         ir_q     <= ir_nx;
         ready_q  <= ready_nx;
         out1_q   <= out1_nx;
         out2_q   <= out2_nx;
         imm_q    <= imm_nx;
         aluop_q  <= aluop_nx;
         neg_q    <= neg_nx;
         immsel_q <= immsel_nx;
         inaddr_q <= inaddr_nx;
         in_q     <= in_nx;
         write_q  <= write_nx;
         rd_q     <= rd_nx;
         wr_q     <= wr_nx;
      end
   end

`ifdef ILLEGAL_OP_CNT_EN
   logic [7:0] ill_q;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)
         ill_q <= '0;
      else if (state == DECODE && !legal && ill_q != 8'hFF)
         ill_q <= ill_q + 8'd1;
   end

   assign bus.ILLEGAL_CNT = ill_q;
`else
   assign bus.ILLEGAL_CNT = 8'h00;
`endif

   assign bus.INSTR_READY = ready_q;
   assign bus.OUT1ADDRESS = out1_q;
   assign bus.OUT2ADDRESS = out2_q;
   assign bus.IMM         = imm_q;
   assign bus.ALUOP       = aluop_q;
   assign bus.NEG_SEL     = neg_q;
   assign bus.IMM_SEL     = immsel_q;
   assign bus.INADDRESS   = inaddr_q;
   assign bus.IN          = in_q;
   assign bus.WRITE       = write_q;
   assign bus.MEM_READ    = rd_q;
   assign bus.MEM_WRITE   = wr_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: fixed vectors, random traffic against a
// transaction-level model, and reset/illegal-opcode corner sequences.
module tb_regfile_sequencer;
   logic CLOCK = 1'b0;
   logic RESET;

   regfile_sequencer_if bus ();

   regfile_sequencer dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {
      logic [31:0] instr;
      logic [7:0]  alu;
      logic [7:0]  rdata;
      int          waits;
      int          wr_cnt;
      int          wr_cyc;
      logic [2:0]  inaddr;
      logic [7:0]  in_val;
      int          mrd;
      int          mwr;
      int          rdy_cyc;
      int          ctl;
      logic [2:0]  aluop;
      logic        neg;
      logic        imms;
      logic [2:0]  a1;
      logic [2:0]  a2;
      logic [7:0]  imm;
   } vec_t;

   typedef struct {
      int         wr_cnt;
      int         wr_cyc;
      logic [2:0] inaddr;
      logic [7:0] in_val;
      int         mrd;
      int         mwr;
      int         rdy_cyc;
      int         both;
      int         timeout;
      logic [2:0] aluop;
      logic       neg;
      logic       imms;
      logic [2:0] a1;
      logic [2:0] a2;
      logic [7:0] imm;
   } obs_t;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Transaction-level expectation derived from the opcode rules.
   function automatic vec_t model(input logic [31:0] instr,
                                  input logic [7:0] alu,
                                  input logic [7:0] rdata,
                                  input int w);
      vec_t e;
      logic [7:0] op;
      logic [2:0] aluop_tab [6];
      aluop_tab = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
      op = instr[31:24];
      e.instr = instr; e.alu = alu; e.rdata = rdata; e.waits = w;
      e.wr_cnt = 0; e.wr_cyc = 0; e.inaddr = instr[18:16];
      e.in_val = 0; e.mrd = 0; e.mwr = 0; e.ctl = 0;
      e.aluop = 0; e.neg = 0; e.imms = 0;
      e.a1 = instr[10:8]; e.a2 = instr[2:0]; e.imm = instr[7:0];
      if (op <= 8'h05) begin
         e.wr_cnt = 1; e.wr_cyc = 3; e.in_val = alu;
         e.rdy_cyc = 4; e.ctl = 1;
         e.aluop = aluop_tab[op[2:0]];
         e.neg = (op == 8'h03);
         e.imms = (op == 8'h00);
      end else if (op == 8'h08) begin
         e.wr_cnt = 1; e.wr_cyc = 4 + w; e.in_val = rdata;
         e.mrd = w + 1; e.rdy_cyc = 5 + w;
      end else if (op == 8'h0A) begin
         e.mwr = w + 1; e.rdy_cyc = 4 + w;
      end else begin
         e.rdy_cyc = 2;
      end
      return e;
   endfunction

   task automatic run_txn(input logic [31:0] instr,
                          input logic [7:0] alu,
                          input logic [7:0] rdata,
                          input int waits,
                          input bit noise,
                          output obs_t o);
      int c, wc;
      bit done;
      o.wr_cnt = 0; o.wr_cyc = 0; o.inaddr = 0; o.in_val = 0;
      o.mrd = 0; o.mwr = 0; o.rdy_cyc = 0; o.both = 0;
      o.timeout = 0; o.aluop = 0; o.neg = 0; o.imms = 0;
      o.a1 = 0; o.a2 = 0; o.imm = 0;
      c = 0;
      while (!bus.INSTR_READY && c < 20) begin
         tick();
         c++;
      end
      if (!bus.INSTR_READY) begin
         o.timeout = 1;
         return;
      end
      bus.INSTR = instr;
      bus.INSTR_VALID = 1'b1;
      bus.ALU_RESULT = alu;
      bus.MEM_READDATA = rdata;
      bus.MEM_BUSYWAIT = 1'b0;
      tick();
      // Offers made while busy must be ignored.
      bus.INSTR_VALID = noise;
      bus.INSTR = $urandom;
      c = 0; wc = 0; done = 0;
      while (!done && c < 40) begin
         tick();
         c++;
         if (bus.WRITE) begin
            if (o.wr_cnt == 0) begin
               o.wr_cyc = c;
               o.in_val = bus.IN;
               o.inaddr = bus.INADDRESS;
            end
            o.wr_cnt++;
         end
         if (bus.MEM_READ) o.mrd++;
         if (bus.MEM_WRITE) o.mwr++;
         if (bus.MEM_READ && bus.MEM_WRITE) o.both = 1;
         if (bus.MEM_READ || bus.MEM_WRITE) begin
            bus.MEM_BUSYWAIT = (wc < waits);
            if (wc < waits) wc++;
         end else begin
            bus.MEM_BUSYWAIT = 1'b0;
         end
         if (bus.INSTR_READY) begin
            done = 1;
            o.rdy_cyc = c;
            bus.INSTR_VALID = 1'b0;
         end
      end
      bus.INSTR_VALID = 1'b0;
      if (!done) o.timeout = 1;
      o.aluop = bus.ALUOP; o.neg = bus.NEG_SEL;
      o.imms = bus.IMM_SEL; o.a1 = bus.OUT1ADDRESS;
      o.a2 = bus.OUT2ADDRESS; o.imm = bus.IMM;
   endtask

   task automatic cmp(input string t, input vec_t e, input obs_t o);
      chk({t, ".timeout"}, o.timeout, 0);
      chk({t, ".wr_cnt"}, o.wr_cnt, e.wr_cnt);
      if (e.wr_cnt != 0) begin
         chk({t, ".wr_cyc"}, o.wr_cyc, e.wr_cyc);
         chk({t, ".inaddr"}, o.inaddr, e.inaddr);
         chk({t, ".in"}, o.in_val, e.in_val);
      end
      chk({t, ".mem_read"}, o.mrd, e.mrd);
      chk({t, ".mem_write"}, o.mwr, e.mwr);
      chk({t, ".rd_wr_both"}, o.both, 0);
      chk({t, ".ready_cyc"}, o.rdy_cyc, e.rdy_cyc);
      chk({t, ".out1"}, o.a1, e.a1);
      chk({t, ".out2"}, o.a2, e.a2);
      chk({t, ".imm"}, o.imm, e.imm);
      if (e.ctl != 0) begin
         chk({t, ".aluop"}, o.aluop, e.aluop);
         chk({t, ".neg"}, o.neg, e.neg);
         chk({t, ".imm_sel"}, o.imms, e.imms);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab [11];
      vec_t e;
      obs_t o;
      int en, wrote;
      logic [7:0] op;
      logic [31:0] ins;
`ifdef ILLEGAL_OP_CNT_EN
      en = 1;
`else
      en = 0;
`endif
      tab[0]  = '{32'h02030102, 8'h15, 8'h00, 0, 1, 3, 3'd3, 8'h15,
                  0, 0, 4, 1, 3'd1, 1'b0, 1'b0, 3'd1, 3'd2, 8'h02};
      tab[1]  = '{32'h08050400, 8'h33, 8'hA7, 3, 1, 7, 3'd5, 8'hA7,
                  4, 0, 8, 0, 3'd0, 1'b0, 1'b0, 3'd4, 3'd0, 8'h00};
      tab[2]  = '{32'h0A000602, 8'h00, 8'h00, 2, 0, 0, 3'd0, 8'h00,
                  0, 3, 6, 0, 3'd0, 1'b0, 1'b0, 3'd6, 3'd2, 8'h02};
      tab[3]  = '{32'h0007005C, 8'h5C, 8'h00, 0, 1, 3, 3'd7, 8'h5C,
                  0, 0, 4, 1, 3'd0, 1'b0, 1'b1, 3'd0, 3'd4, 8'h5C};
      tab[4]  = '{32'h03020405, 8'hF0, 8'h00, 0, 1, 3, 3'd2, 8'hF0,
                  0, 0, 4, 1, 3'd1, 1'b1, 1'b0, 3'd4, 3'd5, 8'h05};
      tab[5]  = '{32'h04010706, 8'h06, 8'h00, 0, 1, 3, 3'd1, 8'h06,
                  0, 0, 4, 1, 3'd2, 1'b0, 1'b0, 3'd7, 3'd6, 8'h06};
      tab[6]  = '{32'h05060203, 8'h7B, 8'h00, 0, 1, 3, 3'd6, 8'h7B,
                  0, 0, 4, 1, 3'd3, 1'b0, 1'b0, 3'd2, 3'd3, 8'h03};
      tab[7]  = '{32'h01040300, 8'h11, 8'h00, 0, 1, 3, 3'd4, 8'h11,
                  0, 0, 4, 1, 3'd0, 1'b0, 1'b0, 3'd3, 3'd0, 8'h00};
      tab[8]  = '{32'h07050102, 8'h99, 8'h00, 0, 0, 0, 3'd0, 8'h00,
                  0, 0, 2, 0, 3'd0, 1'b0, 1'b0, 3'd1, 3'd2, 8'h02};
      tab[9]  = '{32'h08020100, 8'h00, 8'h3C, 0, 1, 4, 3'd2, 8'h3C,
                  1, 0, 5, 0, 3'd0, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00};
      tab[10] = '{32'h0A000305, 8'h00, 8'h00, 0, 0, 0, 3'd0, 8'h00,
                  0, 1, 4, 0, 3'd0, 1'b0, 1'b0, 3'd3, 3'd5, 8'h05};

      bus.INSTR = '0; bus.INSTR_VALID = 1'b0;
      bus.ALU_RESULT = '0; bus.MEM_READDATA = '0;
      bus.MEM_BUSYWAIT = 1'b0;
      RESET = 1'b1;
      #3;
      chk("reset.ready", bus.INSTR_READY, 1);
      chk("reset.write", bus.WRITE, 0);
      chk("reset.mem_read", bus.MEM_READ, 0);
      chk("reset.mem_write", bus.MEM_WRITE, 0);
      chk("reset.in", bus.IN, 0);
      chk("reset.inaddr", bus.INADDRESS, 0);
      chk("reset.out1", bus.OUT1ADDRESS, 0);
      chk("reset.aluop", bus.ALUOP, 0);
      chk("reset.imm", bus.IMM, 0);
      chk("reset.illegal_cnt", bus.ILLEGAL_CNT, 0);
      tick();
      tick();
      RESET = 1'b0;
      tick();
      chk("post_reset.ready", bus.INSTR_READY, 1);

      for (int i = 0; i < 11; i++) begin
         run_txn(tab[i].instr, tab[i].alu, tab[i].rdata,
                 tab[i].waits, 1'b0, o);
         cmp($sformatf("vec%0d", i), tab[i], o);
      end

      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 5) op = 8'(r);
         else if (r == 6) op = 8'h08;
         else if (r == 7) op = 8'h0A;
         else op = 8'(8'h10 + $urandom_range(0, 8'hEF));
         ins = {op, 24'($urandom)};
         e = model(ins, 8'($urandom), 8'($urandom),
                   $urandom_range(0, 3));
         run_txn(ins, e.alu, e.rdata, e.waits, 1'b1, o);
         cmp($sformatf("rnd%0d", i), e, o);
      end

      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      tick();
      chk("cnt_cleared", bus.ILLEGAL_CNT, 0);
      wrote = 0;
      for (int n = 1; n <= 300; n++) begin
         run_txn(32'hFF030102, 8'h55, 8'h66, 0, 1'b0, o);
         wrote += o.wr_cnt + o.mrd + o.mwr + o.timeout;
         chk($sformatf("illegal_cnt%0d", n), bus.ILLEGAL_CNT,
             en * ((n > 255) ? 255 : n));
      end
      chk("illegal.no_side_effects", wrote, 0);
      chk("illegal.final_cnt", bus.ILLEGAL_CNT, en * 255);

      bus.INSTR = 32'h08050400;
      bus.INSTR_VALID = 1'b1;
      bus.MEM_BUSYWAIT = 1'b1;
      tick();
      bus.INSTR_VALID = 1'b0;
      tick();
      tick();
      tick();
      chk("abort.pre_mem_read", bus.MEM_READ, 1);
      #2;
      RESET = 1'b1;
      #1;
      chk("abort.mem_read", bus.MEM_READ, 0);
      chk("abort.write", bus.WRITE, 0);
      chk("abort.mem_write", bus.MEM_WRITE, 0);
      chk("abort.illegal_cnt", bus.ILLEGAL_CNT, 0);
      tick();
      bus.MEM_BUSYWAIT = 1'b0;
      RESET = 1'b0;
      wrote = 0;
      repeat (8) begin
         tick();
         if (bus.WRITE || bus.MEM_READ) wrote++;
      end
      chk("abort.no_write_after", wrote, 0);
      chk("abort.ready", bus.INSTR_READY, 1);
      run_txn(tab[4].instr, tab[4].alu, tab[4].rdata, 0, 1'b0, o);
      cmp("abort.sub", tab[4], o);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have port CLOCK  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port RESET  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port INSTR  in  32  instruction: [31:24] opcode, [18:16] dest, [10:8] src1, [2:0] src2, [7:0] imm.
REQ-004 SHALL have port INSTR_VALID  in  1  instruction offered.
REQ-005 SHALL have port INSTR_READY  out  1  sequencer accepts instruction.
REQ-006 SHALL have port ALU_RESULT  in  8  datapath ALU output.
REQ-007 SHALL have port MEM_READDATA  in  8  data-memory read data.
REQ-008 SHALL have port MEM_BUSYWAIT  in  1  data memory stall.
REQ-009 SHALL have ports OUT1ADDRESS, OUT2ADDRESS  out  3 each  register-file read addresses.
REQ-010 SHALL have ports INADDRESS  out  3, IN  out  8, WRITE  out  1  register-file write port.
REQ-011 SHALL have ports ALUOP  out  3, NEG_SEL  out  1, IMM_SEL  out  1, IMM  out  8  datapath controls.
REQ-012 SHALL have ports MEM_READ, MEM_WRITE  out  1 each; ILLEGAL_CNT  out  8.

Function
REQ-013 SHALL implement states IDLE, DECODE, EXEC, MEMWAIT, WB; all outputs registered.
REQ-014 IDLE: INSTR_READY=1; INSTR_VALID=1 at an edge captures INSTR, goes DECODE; INSTR_READY=0 in all other states.
REQ-015 DECODE: OUT1ADDRESS=src1, OUT2ADDRESS=src2, IMM=imm, driven until next capture.
REQ-016 Opcodes/ALUOP: loadi 0x00 (000, IMM_SEL=1), mov 0x01 (000), add 0x02 (001), sub 0x03 (001, NEG_SEL=1), and 0x04 (010), or 0x05 (011), lwd 0x08, swd 0x0A.
REQ-017 Any other opcode: DECODE -> IDLE, no WRITE, no memory access, illegal count per REQ-027.
REQ-018 EXEC: ALU op latches ALU_RESULT into IN, goes WB; lwd/swd assert MEM_READ/MEM_WRITE, go MEMWAIT.
REQ-019 MEMWAIT: hold MEM_READ/MEM_WRITE while MEM_BUSYWAIT=1; on edge with MEM_BUSYWAIT=0, deassert; lwd latches MEM_READDATA into IN, goes WB; swd goes IDLE.
REQ-020 WB: WRITE=1 exactly one cycle, INADDRESS=dest; then IDLE.
REQ-021 ALU-op latency: captured at edge 0 -> WRITE high cycle 3 -> INSTR_READY high cycle 4.
REQ-022 lwd with zero wait-states: WRITE high cycle 4; each extra MEM_BUSYWAIT cycle adds one.
REQ-023 INSTR_VALID ignored outside IDLE; no queuing.
REQ-024 MEM_READ and MEM_WRITE SHALL never both be 1.

Reset
REQ-025 RESET=1 SHALL immediately force state IDLE and all outputs 0 except INSTR_READY, which is 1 after release; captured instruction cleared.
REQ-026 RESET mid-operation SHALL abort it: WRITE, MEM_READ, MEM_WRITE drop without waiting for an edge; no pending write is issued afterwards.

Configuration
REQ-027 Macro ILLEGAL_OP_CNT_EN: defined -> ILLEGAL_CNT increments per illegal opcode, saturates at 0xFF, cleared by RESET; undefined -> ILLEGAL_CNT tied 0, no counter logic.

Verification
REQ-028 add: INSTR=0x02_03_01_02, VALID one cycle, ALU_RESULT=0x15 -> OUT1ADDRESS=1, OUT2ADDRESS=2, ALUOP=001, WRITE=1 cycle 3, INADDRESS=3, IN=0x15.
REQ-029 lwd: INSTR=0x08_05_04_00, MEM_BUSYWAIT high 3 cycles, MEM_READDATA=0xA7 -> MEM_READ high 4 cycles, WRITE cycle 7, INADDRESS=5, IN=0xA7.
REQ-030 swd with 2 wait cycles -> MEM_WRITE held 3 cycles, WRITE never asserted, INSTR_READY returns 1.
REQ-031 Opcode 0xFF x300 -> no WRITE; ILLEGAL_CNT=0xFF with ILLEGAL_OP_CNT_EN defined, 0 without.
REQ-032 RESET pulsed during MEMWAIT of lwd -> MEM_READ=0 immediately, no WRITE afterwards, INSTR_READY=1 after release, next sub executes normally.
